imsic_msi_arbiter: RTL and testbench

- Shares the IMSIC setipnum write path among NR_REQ MSI requesters, e.g. the AXI register map, the APLIC MSI generator and a debug/test injector.
- Arbitrates round-robin, one MSI accepted per cycle, into a small per-interrupt-file FIFO.
- Each FIFO drains one setipnum write per cycle into its interrupt file, under a per-file ready.
- Sits between the requesters and the interrupt files' setipnum/we inputs.

---
 rtl/imsic_pkg.sv | 18 +
 rtl/imsic_msi_fifo.sv | 45 ++++
 rtl/imsic_msi_arbiter.sv | 116 +++++++++++
 tb/tb_imsic_msi_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_pkg.sv
// Shared types and the invalid-MSI check for the IMSIC setipnum arbiter.
package imsic_pkg;

  localparam int unsigned IMSIC_IDX_W = 32;
  localparam logic [IMSIC_IDX_W-1:0] IMSIC_EIID_RSVD = '0;

  typedef struct packed {
    logic [IMSIC_IDX_W-1:0] file;
    logic [IMSIC_IDX_W-1:0] eiid;
  } imsic_msi_t;

  function automatic logic msi_invalid(imsic_msi_t msi, int unsigned nr_files,
                                       int unsigned nr_src);
    return (msi.file >= nr_files) || (msi.eiid == IMSIC_EIID_RSVD) ||
           (msi.eiid >= nr_src);
  endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// One-push/one-pop synchronous FIFO holding EIIDs queued for one interrupt file.
module imsic_msi_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// Round-robin arbiter sharing the IMSIC setipnum path among MSI requesters,
// with one FIFO per interrupt file and discard of invalid MSIs.
module imsic_msi_arbiter
  import imsic_pkg::*;
#(
  parameter int NR_REQ        = 3,
  parameter int NR_INTP_FILES = 2,
  parameter int NR_SRC_LEN    = 32,
  parameter int NR_SRC        = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int FILE_W        = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
  input  logic                                     i_clk,
  input  logic                                     ni_rst,
  input  logic [NR_REQ-1:0]                        i_req_valid,
  input  logic [NR_REQ-1:0][FILE_W-1:0]            i_req_file,
  input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]        i_req_eiid,
  output logic [NR_REQ-1:0]                        o_req_ready,
  output logic [NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] o_setipnum,
  output logic [NR_INTP_FILES-1:0]                 o_setipnum_we,
  input  logic [NR_INTP_FILES-1:0]                 i_file_ready,
  output logic                                     o_drop,
  output logic                                     o_busy
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]          rr_ptr;
  logic [NR_REQ-1:0]         req_drop;
  logic [NR_REQ-1:0]         req_elig;
  logic                      grant_any;
  logic [PTR_W-1:0]          grant_idx;
  logic                      grant_drop;
  logic [FILE_W-1:0]         grant_file;
  logic [NR_SRC_LEN-1:0]     grant_eiid;
  logic [NR_INTP_FILES-1:0]  fifo_push;
  logic [NR_INTP_FILES-1:0]  fifo_pop;
  logic [NR_INTP_FILES-1:0]  fifo_full;
  logic [NR_INTP_FILES-1:0]  fifo_empty;
  logic [NR_SRC_LEN-1:0]     fifo_head [NR_INTP_FILES];

  // Requests that will be dropped stay eligible so they never stall on a full FIFO.
  always_comb begin
    imsic_msi_t msi;
    logic       tgt_full;
    req_drop = '0;
    req_elig = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      msi.file    = IMSIC_IDX_W'(i_req_file[k]);
      msi.eiid    = IMSIC_IDX_W'(i_req_eiid[k]);
      req_drop[k] = msi_invalid(msi, NR_INTP_FILES, NR_SRC);
      tgt_full    = 1'b0;
      for (int f = 0; f < NR_INTP_FILES; f++) begin
        if (i_req_file[k] == FILE_W'(f)) tgt_full = fifo_full[f];
      end
      req_elig[k] = i_req_valid[k] && (req_drop[k] || !tgt_full);
    end
  end

  always_comb begin
    int idx;
    grant_any   = 1'b0;
    grant_idx   = '0;
    grant_drop  = 1'b0;
    grant_file  = '0;
    grant_eiid  = '0;
    o_req_ready = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NR_REQ;
      if (!grant_any && req_elig[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant_drop = req_drop[idx];
        grant_file = i_req_file[idx];
        grant_eiid = i_req_eiid[idx];
      end
    end
    if (grant_any) o_req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      rr_ptr <= '0;
      o_drop <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(NR_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      o_drop <= grant_any && grant_drop;
    end
  end

  for (genvar f = 0; f < NR_INTP_FILES; f++) begin : g_file
    assign fifo_push[f]     = grant_any && !grant_drop && (grant_file == FILE_W'(f));
    assign fifo_pop[f]      = !fifo_empty[f] && i_file_ready[f];
    assign o_setipnum_we[f] = fifo_pop[f];
    assign o_setipnum[f]    = fifo_empty[f] ? '0 : fifo_head[f];

    imsic_msi_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NR_SRC_LEN)
    ) u_fifo (
      .i_clk   (i_clk),
      .ni_rst  (ni_rst),
      .i_push  (fifo_push[f]),
      .i_data  (grant_eiid),
      .i_pop   (fifo_pop[f]),
      .o_full  (fifo_full[f]),
      .o_empty (fifo_empty[f]),
      .o_head  (fifo_head[f])
    );
  end

  assign o_busy = ~&fifo_empty;

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Scoreboard bench for imsic_msi_arbiter: per-file expected EIID queues popped on setipnum writes.
module tb_imsic_msi_arbiter;

  logic             clk;
  logic             ni_rst;
  logic [2:0]       req_valid;
  logic [2:0][1:0]  req_file;
  logic [2:0][31:0] req_eiid;
  logic [2:0]       req_ready;
  logic [1:0][31:0] setipnum;
  logic [1:0]       setipnum_we;
  logic [1:0]       file_ready;
  logic             drop;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int drop_cnt = 0;
  int we_cnt1  = 0;
  int unsigned q0[$];
  int unsigned q1[$];

  imsic_msi_arbiter #(
    .NR_REQ(3), .NR_INTP_FILES(2), .NR_SRC_LEN(32), .NR_SRC(64), .FIFO_DEPTH(4), .FILE_W(2)
  ) dut (
    .i_clk         (clk),
    .ni_rst        (ni_rst),
    .i_req_valid   (req_valid),
    .i_req_file    (req_file),
    .i_req_eiid    (req_eiid),
    .o_req_ready   (req_ready),
    .o_setipnum    (setipnum),
    .o_setipnum_we (setipnum_we),
    .i_file_ready  (file_ready),
    .o_drop        (drop),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every setipnum write must match the oldest expected EIID for that file.
  always @(negedge clk) begin
    if (setipnum_we[0]) begin
      if (q0.size() == 0) chk("file0_unexpected_we", 64'(setipnum[0]), 64'hdead);
      else chk("file0_eiid", 64'(setipnum[0]), 64'(q0.pop_front()));
    end
    if (setipnum_we[1]) begin
      we_cnt1++;
      if (q1.size() == 0) chk("file1_unexpected_we", 64'(setipnum[1]), 64'hdead);
      else chk("file1_eiid", 64'(setipnum[1]), 64'(q1.pop_front()));
    end
    if (drop) drop_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 after the request is accepted.
  task automatic send(input int k, input int file, input int eiid);
    int n;
    req_valid[k] = 1'b1;
    req_file[k]  = 2'(file);
    req_eiid[k]  = 32'(eiid);
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    ni_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 ni_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    ni_rst     = 1'b0;
    req_valid  = '0;
    req_file   = '0;
    req_eiid   = '0;
    file_ready = 2'b11;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(setipnum_we), 64'd0);
    chk("rst_setipnum", 64'(setipnum), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 ni_rst = 1'b1;

    // Single MSI: ack in the same cycle, setipnum one cycle later.
    q1.push_back(5);
    req_valid[0] = 1'b1; req_file[0] = 2'd1; req_eiid[0] = 32'd5;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b001);
    chk("single_no_bypass", 64'(setipnum_we), 64'd0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_we", 64'(setipnum_we), 64'b10);
    chk("single_eiid", 64'(setipnum[1]), 64'd5);
    @(negedge clk);
    chk("single_busy_clear", 64'(busy), 64'd0);

    // Fairness: round-robin grants 0,1,2,0,1,2 from a fresh pointer.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(32'((i % 3) + 1));
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b1; req_file[k] = 2'd0; req_eiid[k] = 32'(k + 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(3'b001 << (i % 3)));
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk); #1;

    // Backpressure: a full file-0 FIFO must not block requester 1.
    do_reset();
    file_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(32'(10 + i));
      send(0, 0, 10 + i);
    end
    q0.push_back(14);
    q1.push_back(20);
    req_valid[0] = 1'b1; req_file[0] = 2'd0; req_eiid[0] = 32'd14;
    req_valid[1] = 1'b1; req_file[1] = 2'd1; req_eiid[1] = 32'd20;
    @(negedge clk);
    chk("full_skip", 64'(req_ready), 64'b010);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("full_hold", 64'(req_ready), 64'd0);
    @(posedge clk); #1 file_ready = 2'b11;
    @(negedge clk);
    chk("full_pop_no_push", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("full_then_ack", 64'(req_ready), 64'b001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("full_drained", 64'(q0.size()), 64'd0);

    // Drops: reserved EIID, unimplemented EIID, nonexistent file.
    drop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid[2] = 1'b1;
      req_file[2]  = (i == 2) ? 2'd3 : 2'd0;
      req_eiid[2]  = (i == 0) ? 32'd0 : ((i == 1) ? 32'd64 : 32'd5);
      @(negedge clk);
      chk("drop_ack", 64'(req_ready), 64'b100);
      chk("drop_not_yet", 64'(drop), 64'd0);
      @(posedge clk); #1 req_valid[2] = 1'b0;
      @(negedge clk);
      chk("drop_pulse", 64'(drop), 64'd1);
      chk("drop_no_we", 64'(setipnum_we), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drop_count", 64'(drop_cnt), 64'd3);
    @(posedge clk); #1;
    q1.push_back(63);
    send(2, 1, 63);
    repeat (2) @(posedge clk); #1;
    chk("max_eiid_written", 64'(q1.size()), 64'd0);

    // Simultaneous push and pop on a FIFO holding two entries.
    file_ready = 2'b01;
    q1.push_back(30); send(0, 1, 30);
    q1.push_back(31); send(0, 1, 31);
    base = we_cnt1;
    q1.push_back(32);
    file_ready = 2'b11;
    req_valid[0] = 1'b1; req_file[0] = 2'd1; req_eiid[0] = 32'd32;
    @(negedge clk);
    chk("pp_ready", 64'(req_ready), 64'b001);
    chk("pp_we", 64'(setipnum_we[1]), 64'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pp_head", 64'(setipnum[1]), 64'd31);
    repeat (3) @(negedge clk);
    chk("pp_we_count", 64'(we_cnt1 - base), 64'd3);
    chk("pp_busy_clear", 64'(busy), 64'd0);

    // Reset mid-stream discards queued MSIs.
    @(posedge clk); #1;
    file_ready = 2'b10;
    send(0, 0, 40);
    send(1, 0, 41);
    send(2, 0, 42);
    ni_rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_we", 64'(setipnum_we), 64'd0);
    chk("midrst_setipnum", 64'(setipnum), 64'd0);
    @(posedge clk); #1 ni_rst = 1'b1;
    file_ready = 2'b11;
    q0.push_back(50);
    req_valid[0] = 1'b1; req_file[0] = 2'd0; req_eiid[0] = 32'd50;
    @(negedge clk);
    chk("postrst_ready", 64'(req_ready), 64'b001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("postrst_we", 64'(setipnum_we), 64'b01);
    repeat (4) @(negedge clk);
    chk("end_q0_empty", 64'(q0.size()), 64'd0);
    chk("end_q1_empty", 64'(q1.size()), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
